// File: rtl/tmds_serializer_nch.sv
// Multi-channel TMDS symbol serializer: loads one symbol per channel each symbol
// period and shifts it out BITS_PER_CLK bits per clock, with idle fill and bit-slip.
module tmds_serializer_nch #(
    parameter int               NUM_CH       = 3,
    parameter int               SYM_W        = 10,
    parameter int               BITS_PER_CLK = 1,
    parameter bit               LSB_FIRST    = 1'b1,
    parameter logic [SYM_W-1:0] IDLE_SYM     = 10'b1101010100
) (
    input  logic                           pi_clk,
    input  logic                           pi_rst,
    input  logic                           pi_enable,
    input  logic [NUM_CH*SYM_W-1:0]        pi_sym,
    input  logic                           pi_valid,
    output logic                           po_ready,
    input  logic                           pi_bitslip,
    output logic [NUM_CH*BITS_PER_CLK-1:0] po_data,
    output logic                           po_load,
    output logic                           po_underflow,
    output logic [15:0]                    po_underflow_cnt
);

    localparam int S     = SYM_W / BITS_PER_CLK;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(S - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] slot_cnt;
    logic [SYM_W-1:0] shreg [NUM_CH];
    logic             at_last;
    logic             load_en;
    logic             shift_en;
    logic             clear_en;

    assign at_last  = (slot_cnt == LAST_SLOT);
    assign po_ready = load_en;

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bitslip outranks everything in RUN: it freezes the slot, deferring a load or a stop.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        clear_en   = 1'b0;
        case (state)
            IDLE: begin
                if (pi_enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!pi_bitslip) begin
                    if (at_last) begin
                        if (pi_enable) begin
                            load_en = 1'b1;
                        end else begin
                            state_next = IDLE;
                            clear_en   = 1'b1;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            slot_cnt         <= LAST_SLOT;
            po_load          <= 1'b0;
            po_underflow     <= 1'b0;
            po_underflow_cnt <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shreg[ch] <= '0;
            end
        end else begin
            po_load      <= load_en;
            po_underflow <= load_en && !pi_valid;
            if (load_en) begin
                slot_cnt <= '0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    shreg[ch] <= pi_valid ? pi_sym[ch*SYM_W +: SYM_W] : IDLE_SYM;
                end
                if (!pi_valid && (po_underflow_cnt != 16'hFFFF)) begin
                    po_underflow_cnt <= po_underflow_cnt + 16'd1;
                end
            end else if (shift_en) begin
                slot_cnt <= slot_cnt + 1'b1;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (LSB_FIRST) begin
                        shreg[ch] <= shreg[ch] >> BITS_PER_CLK;
                    end else begin
                        shreg[ch] <= shreg[ch] << BITS_PER_CLK;
                    end
                end
            end else if (clear_en) begin
                slot_cnt <= LAST_SLOT;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    shreg[ch] <= '0;
                end
            end
        end
    end

    // MSB-first taps are reversed so the earlier bit always lands at the lower index.
    always_comb begin
        po_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int b = 0; b < BITS_PER_CLK; b++) begin
                po_data[ch*BITS_PER_CLK + b] = LSB_FIRST ? shreg[ch][b] : shreg[ch][SYM_W-1-b];
            end
        end
    end

endmodule

// File: tb/tb_tmds_serializer_nch.sv
// Bench for tmds_serializer_nch: DDR/MSB vector table, directed SDR sequences and
// randomized SDR traffic against a symbol/slot reference model, plus counter saturation.
module tb_tmds_serializer_nch;

    localparam int         S        = 10;
    localparam logic [9:0] IDLE_SYM = 10'b1101010100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic        rst = 1'b1, en = 1'b0, valid = 1'b0, bs = 1'b0;
    logic [29:0] sym = '0;
    logic        ready, load, uf;
    logic [2:0]  data;
    logic [15:0] cnt;

    tmds_serializer_nch dut_sdr (
        .pi_clk(clk), .pi_rst(rst), .pi_enable(en), .pi_sym(sym), .pi_valid(valid),
        .po_ready(ready), .pi_bitslip(bs), .po_data(data), .po_load(load),
        .po_underflow(uf), .po_underflow_cnt(cnt)
    );

    logic        d_rst = 1'b1, d_en = 1'b0, d_valid = 1'b1, d_bs = 1'b0;
    logic [29:0] d_sym = {10'h000, 10'h3FF, 10'b1011001110};
    logic        d_ready, d_load, d_uf;
    logic [5:0]  d_data;
    logic [15:0] d_cnt;

    tmds_serializer_nch #(.BITS_PER_CLK(2), .LSB_FIRST(1'b0)) dut_ddr (
        .pi_clk(clk), .pi_rst(d_rst), .pi_enable(d_en), .pi_sym(d_sym), .pi_valid(d_valid),
        .po_ready(d_ready), .pi_bitslip(d_bs), .po_data(d_data), .po_load(d_load),
        .po_underflow(d_uf), .po_underflow_cnt(d_cnt)
    );

    logic        u_rst = 1'b1, u_en = 1'b0, u_valid = 1'b0, u_bs = 1'b0;
    logic [5:0]  u_sym = 6'b010101;
    logic        u_ready, u_load, u_uf;
    logic [5:0]  u_data;
    logic [15:0] u_cnt;

    tmds_serializer_nch #(.SYM_W(2), .BITS_PER_CLK(2), .IDLE_SYM(2'b10)) dut_sat (
        .pi_clk(clk), .pi_rst(u_rst), .pi_enable(u_en), .pi_sym(u_sym), .pi_valid(u_valid),
        .po_ready(u_ready), .pi_bitslip(u_bs), .po_data(u_data), .po_load(u_load),
        .po_underflow(u_uf), .po_underflow_cnt(u_cnt)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [5:0] data;
        logic       load;
        logic       ready;
    } ddr_vec_t;

    ddr_vec_t ddr_tab [13];

    // Reference model: which symbol is on the wire and which slot of it is showing.
    bit       m_run, m_active, m_load, m_uf;
    int       m_slot, m_cnt;
    bit [9:0] m_sym [3];
    logic     last_ready;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return m_run && (m_slot == S - 1) && (en == 1'b1) && (bs == 1'b0);
    endfunction

    task automatic model_reset();
        m_run = 0; m_active = 0; m_load = 0; m_uf = 0; m_slot = S - 1; m_cnt = 0;
        for (int ch = 0; ch < 3; ch++) m_sym[ch] = '0;
    endtask

    task automatic model_step();
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            model_reset();
        end else begin
            m_load = rdy;
            m_uf   = rdy && !valid;
            if (!m_run) begin
                if (en) m_run = 1;
            end else if (!bs) begin
                if (m_slot == S - 1) begin
                    if (en) begin
                        m_slot   = 0;
                        m_active = 1;
                        for (int ch = 0; ch < 3; ch++) m_sym[ch] = valid ? sym[ch*10 +: 10] : IDLE_SYM;
                        if (!valid && m_cnt < 65535) m_cnt++;
                    end else begin
                        m_run    = 0;
                        m_active = 0;
                    end
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    // One clock of the SDR instance, checked against the model before and after the edge.
    task automatic tick();
        logic [2:0] exp_d;
        #1;
        last_ready = ready;
        checkOutput("ready", ready, model_ready());
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++) exp_d[ch] = m_active ? m_sym[ch][m_slot] : 1'b0;
        checkOutput("data", data, exp_d);
        checkOutput("load", load, m_load);
        checkOutput("underflow", uf, m_uf);
        checkOutput("uf_cnt", cnt, m_cnt);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic v, input logic b, input logic [29:0] s);
        rst = r; en = e; valid = v; bs = b; sym = s;
        tick();
    endtask

    task automatic run_symbol(input logic first_valid, output logic [9:0] c0, output logic [9:0] c1,
                              output logic [9:0] c2, output logic [9:0] ld, output logic [9:0] rd,
                              output logic [9:0] ufv);
        for (int k = 0; k < 10; k++) begin
            valid = (k == 0) ? first_valid : 1'b1;
            tick();
            c0[k] = data[0]; c1[k] = data[1]; c2[k] = data[2];
            ld[k] = load; rd[k] = last_ready; ufv[k] = uf;
        end
        valid = 1'b1;
    endtask

    task automatic measure_period(input int bs_at, output int period, output logic [2:0] win);
        period = 0;
        win    = '0;
        for (int n = 1; n <= 30 && period == 0; n++) begin
            bs = (n == bs_at);
            tick();
            if (n >= 4 && n <= 6) win[n-4] = data[0];
            if (load) period = n;
        end
        bs = 1'b0;
    endtask

    localparam logic [29:0] SYM_A = {10'h000, 10'h3FF, 10'b0000011111};

    initial begin
        logic [9:0] c0, c1, c2, ld, rd, ufv;
        logic [2:0] win;
        logic [7:0] dis1;
        int         period;

        ddr_tab[0]  = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        ddr_tab[1]  = '{1'b0, 1'b1, 6'b000000, 1'b0, 1'b1};
        ddr_tab[2]  = '{1'b0, 1'b1, 6'b001101, 1'b1, 1'b0};
        ddr_tab[3]  = '{1'b0, 1'b1, 6'b001111, 1'b0, 1'b0};
        ddr_tab[4]  = '{1'b0, 1'b1, 6'b001100, 1'b0, 1'b0};
        ddr_tab[5]  = '{1'b0, 1'b1, 6'b001111, 1'b0, 1'b0};
        ddr_tab[6]  = '{1'b0, 1'b1, 6'b001101, 1'b0, 1'b1};
        ddr_tab[7]  = '{1'b0, 1'b1, 6'b001101, 1'b1, 1'b0};
        ddr_tab[8]  = '{1'b0, 1'b0, 6'b001111, 1'b0, 1'b0};
        ddr_tab[9]  = '{1'b0, 1'b0, 6'b001100, 1'b0, 1'b0};
        ddr_tab[10] = '{1'b0, 1'b0, 6'b001111, 1'b0, 1'b0};
        ddr_tab[11] = '{1'b0, 1'b0, 6'b001101, 1'b0, 1'b0};
        ddr_tab[12] = '{1'b0, 1'b0, 6'b000000, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            d_rst = ddr_tab[i].rst;
            d_en  = ddr_tab[i].en;
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("ddr_data[%0d]", i), d_data, ddr_tab[i].data);
            checkOutput($sformatf("ddr_load[%0d]", i), d_load, ddr_tab[i].load);
            checkOutput($sformatf("ddr_ready[%0d]", i), d_ready, ddr_tab[i].ready);
            checkOutput($sformatf("ddr_uf[%0d]", i), d_uf, 1'b0);
        end
        checkOutput("ddr_uf_cnt", d_cnt, 16'd0);

        model_reset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, SYM_A);
        checkOutput("rst_data", data, 3'b000);
        checkOutput("rst_load", load, 1'b0);
        checkOutput("rst_cnt", cnt, 16'd0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, SYM_A);
        for (int rep = 0; rep < 2; rep++) begin
            run_symbol(1'b1, c0, c1, c2, ld, rd, ufv);
            checkOutput("basic_ch0", c0, 10'b0000011111);
            checkOutput("basic_ch1", c1, 10'h3FF);
            checkOutput("basic_ch2", c2, 10'h000);
            checkOutput("basic_load", ld, 10'b0000000001);
            checkOutput("basic_ready", rd, 10'b0000000001);
            checkOutput("basic_uf", ufv, 10'b0);
        end

        run_symbol(1'b0, c0, c1, c2, ld, rd, ufv);
        checkOutput("idle_ch0", c0, IDLE_SYM);
        checkOutput("idle_ch1", c1, IDLE_SYM);
        checkOutput("idle_ch2", c2, IDLE_SYM);
        checkOutput("idle_uf", ufv, 10'b0000000001);
        checkOutput("idle_load", ld, 10'b0000000001);
        checkOutput("idle_cnt", cnt, 16'd1);
        run_symbol(1'b1, c0, c1, c2, ld, rd, ufv);
        checkOutput("resume_ch0", c0, 10'b0000011111);
        checkOutput("resume_uf", ufv, 10'b0);
        checkOutput("resume_cnt", cnt, 16'd1);

        tick();
        checkOutput("bs_align_load", load, 1'b1);
        measure_period(5, period, win);
        checkOutput("bs_mid_period", period, 11);
        checkOutput("bs_mid_bits", win, 3'b011);
        measure_period(0, period, win);
        checkOutput("bs_none_period", period, 10);
        checkOutput("bs_none_bits", win, 3'b001);
        measure_period(10, period, win);
        checkOutput("bs_load_period", period, 11);
        measure_period(0, period, win);
        checkOutput("bs_after_period", period, 10);

        tick(); tick(); tick();
        dis1 = '0;
        dis1[0] = data[1];
        en = 1'b0;
        for (int n = 1; n < 8; n++) begin
            tick();
            dis1[n] = data[1];
        end
        checkOutput("dis_bits", dis1, 8'b0111_1111);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("dis_data", data, 3'b000);
            checkOutput("dis_ready", last_ready, 1'b0);
        end
        checkOutput("dis_cnt", cnt, 16'd1);
        en = 1'b1;
        tick();
        checkOutput("reen_load0", load, 1'b0);
        tick();
        checkOutput("reen_load1", load, 1'b1);
        checkOutput("reen_data", data, 3'b011);

        for (int n = 0; n < 6; n++) tick();
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_data", data, 3'b000);
        checkOutput("mid_rst_load", load, 1'b0);
        checkOutput("mid_rst_cnt", cnt, 16'd0);
        checkOutput("mid_rst_ready", ready, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_load0", load, 1'b0);
        tick();
        checkOutput("post_rst_load1", load, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
                          $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 30'($urandom()));
        end

        u_rst = 1'b0; u_en = 1'b1; u_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("sat_start_cnt", u_cnt, 16'd0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        checkOutput("sat_pre_cnt", u_cnt, 16'd65534);
        checkOutput("sat_uf", u_uf, 1'b1);
        checkOutput("sat_load", u_load, 1'b1);
        checkOutput("sat_ready", u_ready, 1'b1);
        checkOutput("sat_data", u_data, 6'b101010);
        @(posedge clk);
        @(negedge clk);
        checkOutput("sat_max_cnt", u_cnt, 16'hFFFF);
        repeat (100) @(posedge clk);
        @(negedge clk);
        checkOutput("sat_hold_cnt", u_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
